// File: rtl/modulo_rr_server.sv
// Round-robin front end sharing one two-stage Barrett reducer (x mod MODULUS)
// between NUM_REQ valid/ready requesters; results come back tagged with the requester id.
module modulo_rr_server #(
    parameter int              NUM_REQ    = 4,
    parameter int              DATA_WIDTH = 8,
    parameter longint unsigned MODULUS    = 7,
    localparam int             ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int             RES_W      = $clog2(MODULUS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    output logic [RES_W-1:0]              rsp_data_o,
    output logic [ID_W-1:0]               rsp_id_o,
    input  logic                          rsp_ready_i
);

    localparam bit IS_POW2 = ((MODULUS & (MODULUS - 1)) == 0);

    logic [DATA_WIDTH-1:0] req_x [NUM_REQ];
    logic [NUM_REQ-1:0]    upper_mask;
    logic [NUM_REQ-1:0]    req_upper;
    logic [NUM_REQ-1:0]    pick_src;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] acc_x;
    logic [ID_W-1:0]       ptr_q;
    logic [ID_W-1:0]       ptr_d;
    logic                  s1_ready;
    logic                  s2_ready;
    logic                  accept;

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_x_q;
    logic [ID_W-1:0]       s1_id_q;
    logic                  s2_valid_q;
    logic [RES_W-1:0]      s2_res_q;
    logic [ID_W-1:0]       s2_id_q;
    logic [RES_W-1:0]      red_res;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_x[gi]      = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign upper_mask[gi] = (ID_W'(gi) >= ptr_q);
        end
    endgenerate

    // Prefer requesters at or above the pointer; otherwise wrap to the lowest valid one.
    assign req_upper = req_valid_i & upper_mask;
    assign pick_src  = (|req_upper) ? req_upper : req_valid_i;
    assign grant     = pick_src & (~pick_src + NUM_REQ'(1));

    always_comb begin
        grant_idx = '0;
        acc_x     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                grant_idx = grant_idx | ID_W'(j);
                acc_x     = acc_x | req_x[j];
            end
        end
    end

    assign s2_ready    = !s2_valid_q || rsp_ready_i;
    assign s1_ready    = !s1_valid_q || s2_ready;
    assign accept      = s1_ready && (|req_valid_i);
    assign req_ready_o = s1_ready ? grant : '0;
    assign ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    generate
        if (IS_POW2) begin : g_pow2
            logic pow2_unused;
            assign red_res     = s1_x_q[RES_W-1:0];
            assign pow2_unused = ^s1_x_q;
        end else begin : g_barrett
            localparam logic [DATA_WIDTH-1:0] MOD_W = DATA_WIDTH'(MODULUS);
            localparam logic [DATA_WIDTH-1:0] MAGIC = DATA_WIDTH'((64'd1 << DATA_WIDTH) / MODULUS);

            logic [DATA_WIDTH-1:0] q_d;
            logic [DATA_WIDTH-1:0] prod_lo_unused;
            logic [DATA_WIDTH-1:0] s1_q_q;
            logic [DATA_WIDTH-1:0] qm;
            logic [DATA_WIDTH-1:0] r_raw;
            logic [DATA_WIDTH-1:0] r_fix;
            logic                  fix_unused;

            assign {q_d, prod_lo_unused} = {{DATA_WIDTH{1'b0}}, acc_x} * {{DATA_WIDTH{1'b0}}, MAGIC};

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s1_q_q <= '0;
                end else if (accept) begin
                    s1_q_q <= q_d;
                end
            end

            // The quotient estimate is exact or one low, so r < 2*MODULUS and never exceeds x.
            assign qm         = s1_q_q * MOD_W;
            assign r_raw      = s1_x_q - qm;
            assign r_fix      = (r_raw >= MOD_W) ? r_raw - MOD_W : r_raw;
            assign red_res    = r_fix[RES_W-1:0];
            assign fix_unused = ^r_fix;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            if (accept) begin
                ptr_q <= ptr_d;
            end
            if (s1_ready) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_x_q  <= acc_x;
                    s1_id_q <= grant_idx;
                end
            end
            // Result fields only change when a real entry moves in, so idle outputs hold.
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_q <= red_res;
                    s2_id_q  <= s1_id_q;
                end
            end
        end
    end

    assign rsp_valid_o = s2_valid_q;
    assign rsp_data_o  = s2_res_q;
    assign rsp_id_o    = s2_id_q;

endmodule

// File: tb/tb_modulo_rr_server.sv
// Scoreboard bench: four reducers (MODULUS 7, 200, 255, 8) share one stimulus stream;
// every response is compared with x % MODULUS and the originating requester.
module tb_modulo_rr_server;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic           rsp_ready;

    logic [N-1:0] rdy7, rdy200, rdy255, rdy8;
    logic         v7, v200, v255, v8;
    logic [2:0]   d7, d8;
    logic [7:0]   d200, d255;
    logic [1:0]   id7, id200, id255, id8;

    always #5 clk = ~clk;

    modulo_rr_server #(.NUM_REQ(N), .DATA_WIDTH(W), .MODULUS(7)) u_dut7 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(rdy7), .rsp_valid_o(v7), .rsp_data_o(d7), .rsp_id_o(id7),
        .rsp_ready_i(rsp_ready));
    modulo_rr_server #(.NUM_REQ(N), .DATA_WIDTH(W), .MODULUS(200)) u_dut200 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(rdy200), .rsp_valid_o(v200), .rsp_data_o(d200), .rsp_id_o(id200),
        .rsp_ready_i(rsp_ready));
    modulo_rr_server #(.NUM_REQ(N), .DATA_WIDTH(W), .MODULUS(255)) u_dut255 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(rdy255), .rsp_valid_o(v255), .rsp_data_o(d255), .rsp_id_o(id255),
        .rsp_ready_i(rsp_ready));
    modulo_rr_server #(.NUM_REQ(N), .DATA_WIDTH(W), .MODULUS(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(rdy8), .rsp_valid_o(v8), .rsp_data_o(d8), .rsp_id_o(id8),
        .rsp_ready_i(rsp_ready));

    typedef struct {
        int id;
        int x;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[N][$];
    int         grant_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         ncyc = 0;
    logic [N-1:0] acc_mask = '0;
    bit         lat_chk = 1'b0;
    bit         gaps = 1'b0;
    bit         stalls = 1'b0;
    bit         prev_stall = 1'b0;
    logic [2:0] prev_d7 = '0;
    logic [1:0] prev_id = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Handshake monitor: accepts feed the scoreboard, responses drain it.
    always @(negedge clk) begin : mon
        exp_t e;
        ncyc++;
        if (rst) begin
            acc_mask   = '0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            check("ready_onehot", 64'($onehot0(rdy7)), 64'(1));
            check("ready_without_valid", 64'(rdy7 & ~req_valid), 64'(0));
            check("ready_agree", 64'({rdy200, rdy255, rdy8}), 64'({3{rdy7}}));
            check("valid_agree", 64'({v200, v255, v8}), 64'({3{v7}}));
            if (prev_stall) begin
                check("hold_valid", 64'(v7), 64'(1));
                check("hold_data", 64'(d7), 64'(prev_d7));
                check("hold_id", 64'(id7), 64'(prev_id));
            end
            acc_mask = req_valid & rdy7;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) begin
                    e.id  = i;
                    e.x   = int'(req_data[i*W +: W]);
                    e.cyc = ncyc;
                    exp_q.push_back(e);
                end
            end
            if (v7 && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_rsp", 64'(v7), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 64'({id7, id200, id255, id8}), 64'({4{2'(e.id)}}));
                    check("res_m7", 64'(d7), 64'(e.x % 7));
                    check("res_m200", 64'(d200), 64'(e.x % 200));
                    check("res_m255", 64'(d255), 64'(e.x % 255));
                    check("res_m8", 64'(d8), 64'(e.x % 8));
                    if (lat_chk) check("latency", 64'(ncyc - e.cyc), 64'(2));
                    $display("rsp id=%0d x=%0d m7=%0d m200=%0d m255=%0d m8=%0d", e.id, e.x, d7, d200, d255, d8);
                end
            end
            prev_stall = v7 && !rsp_ready;
            prev_d7    = d7;
            prev_id    = id7;
        end
    end

    // One clock of requester behaviour: retire accepted operands, present the next ones.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                void'(src_q[i].pop_front());
                req_valid[i] = 1'b0;
                if (grant_q.size() > 0) check("grant_order", 64'(i), 64'(grant_q.pop_front()));
            end
            if (!req_valid[i] && src_q[i].size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = src_q[i][0];
            end
        end
        if (stalls) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() > 0) || (|req_valid);
        for (int i = 0; i < N; i++) b = b || (src_q[i].size() > 0);
        return b;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 64'(busy()), 64'(0));
        check("grants_seen", 64'(grant_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_valid", 64'({v7, v200, v255, v8}), 64'(0));
        check("rst_data", 64'({d7, d200, d255, d8}), 64'(0));
        check("rst_id", 64'({id7, id8}), 64'(0));
        check("rst_ready", 64'(rdy7), 64'(0));
        rst = 1'b0;

        // All four requesters continuously valid, pointer starts at 0.
        lat_chk = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                src_q[i].push_back(8'((i + 1) * 10));
                grant_q.push_back(i);
            end
        end
        drain(100);

        // Single requester 0, back-to-back operands.
        src_q[0].push_back(8'd0);
        src_q[0].push_back(8'd6);
        src_q[0].push_back(8'd7);
        src_q[0].push_back(8'd13);
        src_q[0].push_back(8'd255);
        drain(100);
        lat_chk = 1'b0;

        // Move the pointer to 2, then contend requesters 1 and 3.
        src_q[1].push_back(8'd50);
        drain(100);
        src_q[1].push_back(8'd11);
        src_q[3].push_back(8'd33);
        src_q[3].push_back(8'd34);
        grant_q.push_back(3);
        grant_q.push_back(1);
        grant_q.push_back(3);
        drain(100);

        // Backpressure: four stalled cycles in the middle of a stream.
        for (int k = 0; k < 10; k++) begin
            src_q[0].push_back(8'(100 + k));
            src_q[2].push_back(8'(150 + k));
        end
        repeat (4) step();
        rsp_ready = 1'b0;
        repeat (4) step();
        check("bp_ready", 64'(rdy7), 64'(0));
        check("bp_inflight", 64'(exp_q.size()), 64'(2));
        rsp_ready = 1'b1;
        drain(200);

        // Reset with two operations in flight.
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) src_q[0].push_back(8'(k * 37));
        repeat (5) step();
        check("pre_rst_inflight", 64'(exp_q.size()), 64'(2));
        check("pre_rst_valid", 64'(v7), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'({v7, v200, v255, v8}), 64'(0));
        check("async_rst_data", 64'({d7, d200, d255, d8}), 64'(0));
        for (int i = 0; i < N; i++) src_q[i].delete();
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) begin
            step();
            check("no_stale", 64'(v7), 64'(0));
        end
        for (int i = 0; i < N; i++) begin
            src_q[i].push_back(8'(200 + i));
            grant_q.push_back(i);
        end
        drain(100);

        // Exhaustive operand sweep with random request gaps and response stalls.
        gaps   = 1'b1;
        stalls = 1'b1;
        for (int x = 0; x < 256; x++) src_q[x % N].push_back(8'(x));
        drain(5000);
        gaps      = 1'b0;
        stalls    = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) step();
        check("idle_valid", 64'(v7), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
